// File: rtl/cam_ov7670_emulator_if.sv
// rtl/cam_ov7670_emulator_if.sv - frame-buffer read port and OV7670-style camera bus
interface cam_ov7670_emulator_if #(
    parameter int ADDR_WIDTH = 19
);
    logic [15:0]           pix_rdata;
    logic [ADDR_WIDTH-1:0] pix_raddr;
    logic                  pix_re;
    logic                  cam_pclk;
    logic                  cam_vsync;
    logic                  cam_href;
    logic [7:0]            cam_data;

    modport master (
        input  pix_rdata,
        output pix_raddr, pix_re, cam_pclk, cam_vsync, cam_href, cam_data
    );

    modport slave (
        output pix_rdata,
        input  pix_raddr, pix_re, cam_pclk, cam_vsync, cam_href, cam_data
    );
endinterface

// File: rtl/cam_ov7670_emulator.sv
// rtl/cam_ov7670_emulator.sv - OV7670-style RGB565 camera transmitter (optional CAM_EMU_TESTPAT_EN test pattern)
module cam_ov7670_emulator #(
    parameter int PCLK_DIV   = 4,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_BLANK    = 144,
    parameter int VS_LINES   = 3,
    parameter int VBP_LINES  = 17,
    parameter int VFP_LINES  = 10,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   enable,
    cam_ov7670_emulator_if.master  cam,
    output logic                   busy,
    output logic                   frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int BYTE_W   = $clog2(LINE_LEN);
    localparam int LINE_W   = $clog2(VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES + 1);
    localparam int DIV_W    = $clog2(PCLK_DIV);
    localparam int LAST_PIX = H_ACTIVE * V_ACTIVE - 1;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BYTE_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [LINE_W-1:0]     line_cnt_q, line_cnt_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  pix_re_q, pix_re_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [15:0]           pixel_q, pixel_d;
    logic                  vsync_q, vsync_d;
    logic                  href_q, href_d;
    logic [7:0]            data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  tick;
    logic                  line_end;
    logic                  phase_end;
    logic                  fetch_next;
    logic [LINE_W-1:0]     phase_last;
    logic [15:0]           pix_next;

    // Index of the last line in the current vertical phase
    always_comb begin
        phase_last = '0;
        case (state_q)
            S_VSYNC:  phase_last = LINE_W'(VS_LINES - 1);
            S_VBP:    phase_last = LINE_W'(VBP_LINES - 1);
            S_ACTIVE: phase_last = LINE_W'(V_ACTIVE - 1);
            S_VFP:    phase_last = LINE_W'(VFP_LINES - 1);
            default:  phase_last = '0;
        endcase
    end

    // Next-state: divider, frame sequencer, counters, prefetch and registered bus outputs
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        line_cnt_d = line_cnt_q;
        raddr_d    = raddr_q;
        vsync_d    = vsync_q;
        href_d     = href_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pix_next   = pixel_q;

        div_cnt_d  = (div_cnt_q == DIV_W'(PCLK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        tick       = (div_cnt_q == '0);
        line_end   = (byte_cnt_q == BYTE_W'(LINE_LEN - 1));
        phase_end  = line_end && (line_cnt_q == phase_last);

        // The period being output precedes an MSB byte: prior LSB, last blank of a line, or last VBP period
        fetch_next = ((state_q == S_ACTIVE) && byte_cnt_q[0] && (byte_cnt_q < BYTE_W'(2 * H_ACTIVE - 1)))
                  || ((state_q == S_ACTIVE) && line_end && (line_cnt_q != LINE_W'(V_ACTIVE - 1)))
                  || ((state_q == S_VBP) && phase_end);

`ifdef CAM_EMU_TESTPAT_EN
        pix_re_d  = 1'b0;
`else
        pix_re_d  = (div_cnt_q == DIV_W'(PCLK_DIV / 2 - 1)) && fetch_next;
`endif
        rd_pend_d = pix_re_q;
        pixel_d   = rd_pend_q ? cam.pix_rdata : pixel_q;

        if (tick) begin
            if (state_q == S_IDLE) begin
                if (enable) begin
                    state_d    = S_VSYNC;
                    byte_cnt_d = '0;
                    line_cnt_d = '0;
                    raddr_d    = '0;
                    busy_d     = 1'b1;
                end
            end else begin
                byte_cnt_d = line_end ? '0 : byte_cnt_q + 1'b1;
                if (line_end) begin
                    line_cnt_d = phase_end ? '0 : line_cnt_q + 1'b1;
                end
                if (phase_end) begin
                    case (state_q)
                        S_VSYNC:  state_d = S_VBP;
                        S_VBP:    state_d = S_ACTIVE;
                        S_ACTIVE: state_d = S_VFP;
                        S_VFP: begin
                            done_d = 1'b1;
                            if (enable) begin
                                state_d = S_VSYNC;
                                raddr_d = '0;
                            end else begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                        default:  state_d = S_IDLE;
                    endcase
                end
            end

`ifdef CAM_EMU_TESTPAT_EN
            begin : testpat
                logic [15:0] line_ext;
                logic [15:0] col_ext;
                line_ext = 16'(line_cnt_d);
                col_ext  = 16'(byte_cnt_d >> 1);
                pix_next = {line_ext[7:0], col_ext[7:0]};
            end
`endif

            vsync_d = (state_d == S_VSYNC);
            href_d  = (state_d == S_ACTIVE) && (byte_cnt_d < BYTE_W'(2 * H_ACTIVE));
            data_d  = href_d ? (byte_cnt_d[0] ? pix_next[7:0] : pix_next[15:8]) : 8'h00;
            if (href_d && byte_cnt_d[0] && (raddr_q != ADDR_WIDTH'(LAST_PIX))) begin
                raddr_d = raddr_q + 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            byte_cnt_q <= '0;
            line_cnt_q <= '0;
            raddr_q    <= '0;
            pix_re_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            pixel_q    <= '0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            line_cnt_q <= line_cnt_d;
            raddr_q    <= raddr_d;
            pix_re_q   <= pix_re_d;
            rd_pend_q  <= rd_pend_d;
            pixel_q    <= pixel_d;
            vsync_q    <= vsync_d;
            href_q     <= href_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cam.cam_pclk  = (div_cnt_q >= DIV_W'(PCLK_DIV / 2));
    assign cam.cam_vsync = vsync_q;
    assign cam.cam_href  = href_q;
    assign cam.cam_data  = data_q;
    assign cam.pix_re    = pix_re_q;
    assign cam.pix_raddr = raddr_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
endmodule

// File: tb/tb_cam_ov7670_emulator.sv
// tb/tb_cam_ov7670_emulator.sv - scoreboard bench for cam_ov7670_emulator on a small frame
module tb_cam_ov7670_emulator;
    localparam int DIV       = 4;
    localparam int H_ACT     = 4;
    localparam int V_ACT     = 2;
    localparam int H_BLK     = 4;
    localparam int AW        = 19;
    localparam int FRAME_CYC = 240;
`ifdef CAM_EMU_TESTPAT_EN
    localparam int EXP_RE    = 0;
`else
    localparam int EXP_RE    = 8;
`endif

    logic sys_clk;
    logic rst_n;
    logic enable;
    logic busy;
    logic frame_done;

    cam_ov7670_emulator_if #(.ADDR_WIDTH(AW)) cam_if();

    cam_ov7670_emulator #(
        .PCLK_DIV(DIV), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_BLANK(H_BLK),
        .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1), .ADDR_WIDTH(AW)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .enable(enable),
        .cam(cam_if),
        .busy(busy),
        .frame_done(frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    int done_cnt = 0;
    int byte_cnt = 0;
    int re_cnt   = 0;
    int cyc      = 0;
    int vs_start = 0;
    logic prev_pclk  = 1'b0;
    logic prev_vsync = 1'b0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    // Synchronous-read frame buffer: address n holds 16'hA000 + n
    always @(posedge sys_clk) begin
        if (cam_if.pix_re) cam_if.pix_rdata <= 16'hA000 + 16'(cam_if.pix_raddr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int r, input int c);
`ifdef CAM_EMU_TESTPAT_EN
        exp_pix = {r[7:0], c[7:0]};
`else
        exp_pix = 16'hA000 + 16'(r * H_ACT + c);
`endif
    endfunction

    task automatic push_frame();
        logic [15:0] p;
        for (int r = 0; r < V_ACT; r++) begin
            for (int c = 0; c < H_ACT; c++) begin
                p = exp_pix(r, c);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
        end
    endtask

    // Monitor: bytes on PCLK rise during href, frame_done count and frame length, read strobes
    always @(negedge sys_clk) begin
        logic [7:0] e;
        if (cam_if.cam_pclk && !prev_pclk && cam_if.cam_href) begin
            if (exp_q.size() == 0) begin
                check("byte_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("byte", 32'(cam_if.cam_data), 32'(e));
                byte_cnt++;
            end
        end
        if (cam_if.pix_re) re_cnt++;
        if (frame_done) begin
            done_cnt++;
            check("frame_len", 32'(cyc - vs_start), 32'(FRAME_CYC));
        end
        if (cam_if.cam_vsync && !prev_vsync) vs_start = cyc;
        prev_pclk  = cam_if.cam_pclk;
        prev_vsync = cam_if.cam_vsync;
    end

    task automatic wait_href(input string name);
        int n = 0;
        while (!cam_if.cam_href && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 2000) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!frame_done && n < 2000);
        if (n >= 2000) check(name, 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        all_outs = 32'({cam_if.cam_vsync, cam_if.cam_href, cam_if.cam_data, cam_if.cam_pclk,
                        cam_if.pix_re, busy, frame_done, cam_if.pix_raddr});
    endfunction

    initial begin
        int d0;
        rst_n  = 1'b0;
        enable = 1'b0;

        // Reset: outputs held at 0, pclk static
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk); #1;
            check("reset_pclk", 32'(cam_if.cam_pclk), 32'd0);
        end
        check("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;

        // PCLK: period 4, 2 low then 2 high
        for (int k = 1; k <= 8; k++) begin
            @(posedge sys_clk); #1;
            check("pclk_phase", 32'(cam_if.cam_pclk), 32'((k % 4) >= 2));
        end

        // Single frame with enable dropped mid active line
        re_cnt = 0;
        push_frame();
        enable = 1'b1;
        wait_href("timeout_href1");
        enable = 1'b0;
        wait_done("timeout_done1");
        check("f1_raddr_end", 32'(cam_if.pix_raddr), 32'd7);
        check("f1_busy_end", 32'(busy), 32'd0);
        check("f1_vsync_end", 32'(cam_if.cam_vsync), 32'd0);
        repeat (300) @(negedge sys_clk);
        check("f1_done_cnt", 32'(done_cnt), 32'd1);
        check("f1_idle_vsync", 32'(cam_if.cam_vsync), 32'd0);
        check("f1_bytes", 32'(byte_cnt), 32'd16);
        check("f1_sb_empty", 32'(exp_q.size()), 32'd0);
        check("f1_pix_re_cnt", 32'(re_cnt), 32'(EXP_RE));

        // Back-to-back frames, no gap between frame_done and next vsync
        re_cnt = 0;
        push_frame();
        push_frame();
        enable = 1'b1;
        wait_done("timeout_done2");
        check("b2b_vsync_at_done", 32'(cam_if.cam_vsync), 32'd1);
        check("b2b_busy_at_done", 32'(busy), 32'd1);
        wait_href("timeout_href2");
        enable = 1'b0;
        wait_done("timeout_done3");
        check("b2b_busy_end", 32'(busy), 32'd0);
        repeat (300) @(negedge sys_clk);
        check("b2b_done_cnt", 32'(done_cnt), 32'd3);
        check("b2b_bytes", 32'(byte_cnt), 32'd48);
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
        check("b2b_pix_re_cnt", 32'(re_cnt), 32'(2 * EXP_RE));

        // Reset during S_ACTIVE, then a fresh frame
        push_frame();
        enable = 1'b1;
        wait_href("timeout_href3");
        repeat (5) @(negedge sys_clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(posedge sys_clk); #1;
        check("midrst_outputs", all_outs(), 32'd0);
        enable = 1'b0;
        exp_q.delete();
        repeat (10) @(posedge sys_clk);
        #1;
        check("midrst_no_done", 32'(done_cnt), 32'(d0));
        re_cnt = 0;
        push_frame();
        rst_n  = 1'b1;
        enable = 1'b1;
        begin
            int n = 0;
            while (!cam_if.cam_vsync && n < 100) begin
                @(negedge sys_clk);
                n++;
            end
            check("fresh_vsync_seen", 32'(cam_if.cam_vsync), 32'd1);
        end
        check("fresh_raddr0", 32'(cam_if.pix_raddr), 32'd0);
        wait_href("timeout_href4");
        enable = 1'b0;
        wait_done("timeout_done4");
        check("fresh_raddr_end", 32'(cam_if.pix_raddr), 32'd7);
        repeat (50) @(negedge sys_clk);
        check("fresh_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        check("fresh_sb_empty", 32'(exp_q.size()), 32'd0);
        check("fresh_pix_re_cnt", 32'(re_cnt), 32'(EXP_RE));
        check("fresh_busy_end", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
